// File: rtl/vc_output_scheduler.sv
// Output-port scheduler: packet-granular round-robin sharing of one outbound flit
// channel among NUM_VCS virtual channels, gated by per-VC downstream credits.
// Per-VC vectors and credit_count fields place VC0 in the most significant position.
module vc_output_scheduler #(
  parameter int unsigned NUM_VCS      = 4,
  parameter int unsigned VC_IDX_WIDTH = 2,
  parameter int unsigned BUF_DEPTH    = 4,
  parameter int unsigned CRED_WIDTH   = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_VCS-1:0]             req,
  input  logic [NUM_VCS-1:0]             req_head,
  input  logic [NUM_VCS-1:0]             req_tail,
  input  logic                           credit_valid,
  input  logic [VC_IDX_WIDTH-1:0]        credit_vc,
  output logic [NUM_VCS-1:0]             gnt,
  output logic                           flit_valid,
  output logic [VC_IDX_WIDTH-1:0]        flit_vc,
  output logic                           locked,
  output logic [NUM_VCS*CRED_WIDTH-1:0]  credit_count,
  output logic                           error
);

  localparam logic [CRED_WIDTH-1:0]   CRED_FULL = CRED_WIDTH'(BUF_DEPTH);
  localparam logic [VC_IDX_WIDTH-1:0] LAST_VC   = VC_IDX_WIDTH'(NUM_VCS - 1);
  localparam logic [VC_IDX_WIDTH:0]   VC_LIMIT  = (VC_IDX_WIDTH + 1)'(NUM_VCS);

  typedef enum logic {
    S_IDLE,
    S_LOCKED
  } state_t;

  state_t                    state_q, state_d;
  logic [VC_IDX_WIDTH-1:0]   owner_q, owner_d;
  logic [VC_IDX_WIDTH-1:0]   ptr_q, ptr_d;
  logic                      error_q, error_d;
  logic [CRED_WIDTH-1:0]     credit_q [NUM_VCS];
  logic [CRED_WIDTH-1:0]     credit_d [NUM_VCS];

  // Internal vectors are indexed by VC number (bit v = VC v)
  logic [NUM_VCS-1:0]        req_v, head_v, tail_v;
  logic [NUM_VCS-1:0]        elig, cand, gnt_v, ret, ovf;
  logic                      vc_ok;
  logic                      win_found;
  logic [VC_IDX_WIDTH-1:0]   win_idx;
  logic [VC_IDX_WIDTH-1:0]   sel_vc;
  logic                      head_err;
  int unsigned               idx;

  assign vc_ok = ({1'b0, credit_vc} < VC_LIMIT);

  for (genvar v = 0; v < NUM_VCS; v++) begin : g_vc
    assign req_v[v]  = req[NUM_VCS-1-v];
    assign head_v[v] = req_head[NUM_VCS-1-v];
    assign tail_v[v] = req_tail[NUM_VCS-1-v];
    assign elig[v]   = req_v[v] & (credit_q[v] != '0);
    assign cand[v]   = elig[v] & head_v[v];
    assign gnt[NUM_VCS-1-v] = gnt_v[v];
    assign credit_count[(NUM_VCS-1-v)*CRED_WIDTH +: CRED_WIDTH] = credit_q[v];

    assign ret[v] = credit_valid & vc_ok & (credit_vc == VC_IDX_WIDTH'(v));
    assign ovf[v] = ret[v] & ~gnt_v[v] & (credit_q[v] == CRED_FULL);

    // Net credit change: +1 on return, -1 on grant; a return at full saturates
    always_comb begin
      credit_d[v] = credit_q[v];
      if (ret[v] && !gnt_v[v]) begin
        if (credit_q[v] != CRED_FULL) credit_d[v] = credit_q[v] + CRED_WIDTH'(1);
      end else if (!ret[v] && gnt_v[v]) begin
        credit_d[v] = credit_q[v] - CRED_WIDTH'(1);
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) credit_q[v] <= CRED_FULL;
      else       credit_q[v] <= credit_d[v];
    end
  end

  // Round-robin search: first head candidate at or after ptr_q, wrapping
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int unsigned i = 0; i < NUM_VCS; i++) begin
      idx = 32'(ptr_q) + i;
      if (idx >= NUM_VCS) idx = idx - NUM_VCS;
      if (!win_found && cand[VC_IDX_WIDTH'(idx)]) begin
        win_found = 1'b1;
        win_idx   = VC_IDX_WIDTH'(idx);
      end
    end
  end

  // Next-state, grant and pointer logic
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    gnt_v    = '0;
    sel_vc   = '0;
    head_err = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          gnt_v[win_idx] = 1'b1;
          sel_vc         = win_idx;
          ptr_d          = (win_idx == LAST_VC) ? '0 : win_idx + VC_IDX_WIDTH'(1);
          if (!tail_v[win_idx]) begin
            state_d = S_LOCKED;
            owner_d = win_idx;
          end
        end
      end
      S_LOCKED: begin
        if (elig[owner_q]) begin
          gnt_v[owner_q] = 1'b1;
          sel_vc         = owner_q;
          head_err       = head_v[owner_q];
          if (tail_v[owner_q]) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign error_d    = error_q | head_err | (|ovf) | (credit_valid & ~vc_ok);
  assign flit_valid = |gnt_v;
  assign flit_vc    = sel_vc;
  assign locked     = (state_q == S_LOCKED);
  assign error      = error_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      error_q <= error_d;
    end
  end

endmodule

// File: tb/tb_vc_output_scheduler.sv
// Directed + randomized bench for vc_output_scheduler with a packet-level
// reference model of arbitration, wormhole locking and credit accounting.
module tb_vc_output_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req, req_head, req_tail;
  logic        credit_valid;
  logic [1:0]  credit_vc;
  logic [3:0]  gnt;
  logic        flit_valid;
  logic [1:0]  flit_vc;
  logic        locked;
  logic [11:0] credit_count;
  logic        error;

  vc_output_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .req_head     (req_head),
    .req_tail     (req_tail),
    .credit_valid (credit_valid),
    .credit_vc    (credit_vc),
    .gnt          (gnt),
    .flit_valid   (flit_valid),
    .flit_vc      (flit_vc),
    .locked       (locked),
    .credit_count (credit_count),
    .error        (error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_cred [4];
  bit m_locked;
  int m_owner;
  int m_ptr;
  bit m_err;

  // Observations from the most recent step
  logic [3:0]  obs_gnt;
  logic        obs_locked;
  logic [11:0] obs_cc;
  logic        obs_err;

  function automatic logic [3:0] vbit(input int v);
    logic [3:0] b;
    b = 4'b1000 >> v;
    return b;
  endfunction

  function automatic bit has(input logic [3:0] vec, input int v);
    return (vec & vbit(v)) != 4'b0000;
  endfunction

  function automatic logic [11:0] model_cc();
    return {3'(m_cred[0]), 3'(m_cred[1]), 3'(m_cred[2]), 3'(m_cred[3])};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int v = 0; v < 4; v++) m_cred[v] = 4;
    m_locked = 0;
    m_owner  = 0;
    m_ptr    = 0;
    m_err    = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req = '0; req_head = '0; req_tail = '0;
    credit_valid = 1'b0; credit_vc = '0;
    model_reset();
    #1;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_flit_valid", 32'(flit_valid), 32'h0);
    chk("rst_flit_vc", 32'(flit_vc), 32'h0);
    chk("rst_locked", 32'(locked), 32'h0);
    chk("rst_credits", 32'(credit_count), 32'h924);
    chk("rst_error", 32'(error), 32'h0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One cycle: drive, compare combinational/registered outputs, then advance model
  task automatic step(input logic [3:0] rq, input logic [3:0] hd, input logic [3:0] tl,
                      input logic cv, input logic [1:0] cvc);
    int g;
    int v;
    @(negedge clk);
    req = rq; req_head = hd; req_tail = tl;
    credit_valid = cv; credit_vc = cvc;
    #1;
    g = -1;
    if (!m_locked) begin
      for (int i = 0; i < 4; i++) begin
        v = (m_ptr + i) % 4;
        if (g < 0 && has(rq, v) && has(hd, v) && m_cred[v] > 0) g = v;
      end
    end else if (has(rq, m_owner) && m_cred[m_owner] > 0) begin
      g = m_owner;
    end
    chk("gnt", 32'(gnt), (g < 0) ? 32'h0 : 32'(vbit(g)));
    chk("flit_valid", 32'(flit_valid), (g < 0) ? 32'h0 : 32'h1);
    chk("flit_vc", 32'(flit_vc), (g < 0) ? 32'h0 : 32'(g));
    chk("locked", 32'(locked), 32'(m_locked));
    chk("credit_count", 32'(credit_count), 32'(model_cc()));
    chk("error", 32'(error), 32'(m_err));
    obs_gnt = gnt; obs_locked = locked; obs_cc = credit_count; obs_err = error;
    @(posedge clk);
    if (g >= 0) begin
      if (!m_locked) begin
        m_ptr = (g + 1) % 4;
        if (!has(tl, g)) begin
          m_locked = 1;
          m_owner  = g;
        end
      end else begin
        if (has(hd, g)) m_err = 1;
        if (has(tl, g)) m_locked = 0;
      end
    end
    for (int u = 0; u < 4; u++) begin
      bit r;
      r = cv && (int'(cvc) == u);
      if (r && g != u && m_cred[u] == 4) m_err = 1;
      else m_cred[u] = m_cred[u] + (r ? 1 : 0) - ((g == u) ? 1 : 0);
    end
  endtask

  initial begin
    reset = 1'b1;
    req = '0; req_head = '0; req_tail = '0;
    credit_valid = 1'b0; credit_vc = '0;
    model_reset();

    // Single-flit packets on all VCs rotate 0,1,2,3,0; each credit comes straight back
    do_reset();
    for (int k = 0; k < 5; k++) begin
      step(4'b1111, 4'b1111, 4'b1111, 1'b1, 2'(k % 4));
      chk("t1_gnt", 32'(obs_gnt), 32'(vbit(k % 4)));
      chk("t1_locked", 32'(obs_locked), 32'h0);
    end

    // VC1 three-flit packet holds the channel against VC2's head
    do_reset();
    step(4'b0110, 4'b0110, 4'b0000, 1'b0, 2'd0);
    chk("t2_c1_gnt", 32'(obs_gnt), 32'h4);
    chk("t2_c1_locked", 32'(obs_locked), 32'h0);
    step(4'b0110, 4'b0010, 4'b0000, 1'b0, 2'd0);
    chk("t2_c2_gnt", 32'(obs_gnt), 32'h4);
    chk("t2_c2_locked", 32'(obs_locked), 32'h1);
    step(4'b0110, 4'b0010, 4'b0100, 1'b0, 2'd0);
    chk("t2_c3_gnt", 32'(obs_gnt), 32'h4);
    chk("t2_c3_locked", 32'(obs_locked), 32'h1);
    step(4'b0010, 4'b0010, 4'b0000, 1'b0, 2'd0);
    chk("t2_c4_gnt", 32'(obs_gnt), 32'h2);
    chk("t2_vc1_cred", 32'((obs_cc >> 6) & 12'h7), 32'h1);

    // VC0 drains its credits, stalls, then resumes after one return
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step(4'b1000, 4'b1000, 4'b1000, 1'b0, 2'd0);
      chk("t3_gnt", 32'(obs_gnt), 32'h8);
    end
    step(4'b1000, 4'b1000, 4'b1000, 1'b0, 2'd0);
    chk("t3_empty_cred", 32'((obs_cc >> 9) & 12'h7), 32'h0);
    chk("t3_stall_gnt", 32'(obs_gnt), 32'h0);
    step(4'b1000, 4'b1000, 4'b1000, 1'b1, 2'd0);
    chk("t3_ret_gnt", 32'(obs_gnt), 32'h0);
    step(4'b1000, 4'b1000, 4'b1000, 1'b0, 2'd0);
    chk("t3_resume_gnt", 32'(obs_gnt), 32'h8);

    // Grant and return on VC3 in the same cycle cancel out
    do_reset();
    step(4'b0001, 4'b0001, 4'b0001, 1'b0, 2'd0);
    step(4'b0001, 4'b0001, 4'b0001, 1'b0, 2'd0);
    step(4'b0001, 4'b0001, 4'b0001, 1'b1, 2'd3);
    chk("t4_gnt", 32'(obs_gnt), 32'h1);
    chk("t4_cred_before", 32'(obs_cc & 12'h7), 32'h2);
    step(4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0);
    chk("t4_cred_after", 32'(obs_cc & 12'h7), 32'h2);
    chk("t4_error", 32'(obs_err), 32'h0);

    // Return to a full VC2 is an overflow: sticky error, count saturates
    step(4'b0000, 4'b0000, 4'b0000, 1'b1, 2'd2);
    step(4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0);
    chk("t5_error", 32'(obs_err), 32'h1);
    chk("t5_vc2_cred", 32'((obs_cc >> 3) & 12'h7), 32'h4);
    step(4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0);
    chk("t5_sticky", 32'(obs_err), 32'h1);
    do_reset();

    // Reset mid-packet abandons VC1's packet and the pointer
    step(4'b0100, 4'b0100, 4'b0000, 1'b0, 2'd0);
    step(4'b0100, 4'b0000, 4'b0000, 1'b0, 2'd0);
    chk("t6_locked_pre", 32'(obs_locked), 32'h1);
    do_reset();
    step(4'b0111, 4'b0111, 4'b0111, 1'b0, 2'd0);
    chk("t6_gnt", 32'(obs_gnt), 32'h4);

    // Randomized traffic, occasionally reset to re-arm the sticky error
    for (int blk = 0; blk < 4; blk++) begin
      do_reset();
      for (int n = 0; n < 150; n++) begin
        logic [3:0] rq, hd, tl;
        logic       cv;
        logic [1:0] cvc;
        rq  = 4'($urandom);
        hd  = 4'($urandom) & 4'($urandom);
        tl  = 4'($urandom);
        cvc = 2'($urandom_range(3));
        cv  = 1'($urandom);
        if (cv && m_cred[cvc] == 4 && $urandom_range(15) != 0) cv = 1'b0;
        step(rq, hd, tl, cv, cvc);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
